mant_gate_pipe: RTL and testbench

Registered, multi-lane successor to the single 52-bit mantissa gate in the FP multiplier front end. Per lane, it classifies an IEEE operand from its exponent field. It then emits the significand with the hidden bit restored, flushed to zero, or passed as a denormal, together with zero and special flags. A valid/ready handshake with a 2-entry skid buffer lets it sit between operand unpacking and the Vedic partial-product array at full throughput.

---
 rtl/mant_gate_pkg.sv | 21 ++
 rtl/mant_gate_pipe_if.sv | 45 ++++
 rtl/mant_gate_lane.sv | 35 +++
 rtl/mant_gate_pipe.sv | 172 +++++++++++++++++
 tb/tb_mant_gate_pipe.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mant_gate_pkg.sv
// Shared types and default widths for the mantissa gate pipeline.
// Optional gate statistics are enabled with MANT_GATE_STATS_EN.
package mant_gate_pkg;

    typedef enum logic {
        MODE_FTZ    = 1'b0,
        MODE_DENORM = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam int DP_MANT_W = 52;
    localparam int DP_EXP_W  = 11;
    localparam int SP_MANT_W = 23;
    localparam int SP_EXP_W  = 8;

endpackage

// File: rtl/mant_gate_pipe_if.sv
// Valid/ready bundle between operand unpack and the gate pipeline.
// master drives beats in and accepts results; slave is the pipeline.
interface mant_gate_if #(
    parameter int MANT_W = 52,
    parameter int EXP_W  = 11,
    parameter int LANES  = 2
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*MANT_W-1:0]     in_mant;
    logic [LANES*EXP_W-1:0]      in_exp;
    logic                        in_mode;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*(MANT_W+1)-1:0] out_sig;
    logic [LANES-1:0]            out_zero;
    logic [LANES-1:0]            out_special;

    modport master (
        output in_valid,
        output in_mant,
        output in_exp,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sig,
        input  out_zero,
        input  out_special
    );

    modport slave (
        input  in_valid,
        input  in_mant,
        input  in_exp,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sig,
        output out_zero,
        output out_special
    );

endinterface

// File: rtl/mant_gate_lane.sv
// Combinational per-lane operand classifier and significand gate.
// Part of mant_gate_pipe (stats build: MANT_GATE_STATS_EN).
module mant_gate_lane
    import mant_gate_pkg::*;
#(
    parameter int MANT_W = DP_MANT_W,
    parameter int EXP_W  = DP_EXP_W
) (
    input  logic [MANT_W-1:0] mant,
    input  logic [EXP_W-1:0]  expn,
    input  mode_e             mode,
    output logic [MANT_W:0]   sig,
    output logic              zero,
    output logic              special,
    output logic              flushed
);

    always_comb begin
        sig     = '0;
        zero    = 1'b0;
        special = 1'b0;
        flushed = 1'b0;
        if (expn != '0) begin
            sig     = {1'b1, mant};
            special = &expn;
        end else if (mode == MODE_DENORM) begin
            sig  = {1'b0, mant};
            zero = (mant == '0);
        end else begin
            zero    = 1'b1;
            flushed = 1'b1;
        end
    end

endmodule

// File: rtl/mant_gate_pipe.sv
// Multi-lane mantissa gate with a 2-entry skid buffer.
// Define MANT_GATE_STATS_EN to add the saturating gate_cnt counter.
module mant_gate_pipe
    import mant_gate_pkg::*;
#(
    parameter int MANT_W = DP_MANT_W,
    parameter int EXP_W  = DP_EXP_W,
    parameter int LANES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    mant_gate_if.slave  bus
`ifdef MANT_GATE_STATS_EN
    ,
    output logic [31:0] gate_cnt
`endif
);

    localparam int SW = LANES * (MANT_W + 1);
    localparam int BW = SW + 2 * LANES;

    logic [SW-1:0]    sig_d;
    logic [LANES-1:0] zero_d;
    logic [LANES-1:0] spec_d;
    logic [BW-1:0]    beat_d;
    logic [BW-1:0]    out_q;
    logic [BW-1:0]    skid_q;

`ifdef MANT_GATE_STATS_EN
    logic [LANES-1:0] fl_d;
    logic [LANES-1:0] out_fl_q;
    logic [LANES-1:0] skid_fl_q;
`else
    logic [LANES-1:0] fl_unused;
`endif

    occ_e state_q;
    occ_e state_d;
    logic in_ready_q;
    logic out_valid;
    logic acc;
    logic pop;
    logic ld_out;
    logic ld_skid;
    logic out_from_skid;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mant_gate_lane #(
            .MANT_W (MANT_W),
            .EXP_W  (EXP_W)
        ) u_lane (
            .mant    (bus.in_mant[l*MANT_W +: MANT_W]),
            .expn    (bus.in_exp[l*EXP_W +: EXP_W]),
            .mode    (mode_e'(bus.in_mode)),
            .sig     (sig_d[l*(MANT_W+1) +: MANT_W+1]),
            .zero    (zero_d[l]),
            .special (spec_d[l]),
`ifdef MANT_GATE_STATS_EN
            .flushed (fl_d[l])
`else
            .flushed (fl_unused[l])
`endif
        );
    end

    assign beat_d    = {sig_d, zero_d, spec_d};
    assign out_valid = (state_q != EMPTY);
    assign acc       = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    // Ready is a flop so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (acc) state_d = ONE;
            ONE: begin
                if (acc && !pop)
                    state_d = TWO;
                else if (!acc && pop)
                    state_d = EMPTY;
            end
            TWO: if (!acc && pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        ld_out        = 1'b0;
        ld_skid       = 1'b0;
        out_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: ld_out = acc;
            ONE: begin
                ld_out  = acc & pop;
                ld_skid = acc & ~pop;
            end
            TWO: begin
                ld_out        = pop;
                out_from_skid = pop;
                ld_skid       = acc & pop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (ld_out)
                out_q <= out_from_skid ? skid_q : beat_d;
            if (ld_skid)
                skid_q <= beat_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_sig     = out_q[BW-1 -: SW];
    assign bus.out_zero    = out_q[2*LANES-1 -: LANES];
    assign bus.out_special = out_q[LANES-1:0];

`ifdef MANT_GATE_STATS_EN
    localparam int CW = $clog2(LANES + 1);

    logic [31:0]   gate_cnt_q;
    logic [CW-1:0] fl_n;
    logic [32:0]   cnt_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_fl_q  <= '0;
            skid_fl_q <= '0;
        end else begin
            if (ld_out)
                out_fl_q <= out_from_skid ? skid_fl_q : fl_d;
            if (ld_skid)
                skid_fl_q <= fl_d;
        end
    end

    always_comb begin
        fl_n = '0;
        for (int l = 0; l < LANES; l++)
            fl_n = fl_n + CW'(out_fl_q[l]);
    end

    assign cnt_sum = {1'b0, gate_cnt_q} + 33'(fl_n);

    // Counted on output transfer, so a reset flushes uncounted beats too.
    always_ff @(posedge clk) begin
        if (rst)
            gate_cnt_q <= '0;
        else if (pop)
            gate_cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end

    assign gate_cnt = gate_cnt_q;
`endif

endmodule

// File: tb/tb_mant_gate_pipe.sv
// Scoreboard bench for mant_gate_pipe, default and
// MANT_GATE_STATS_EN builds.
module tb_mant_gate_pipe;

    localparam int MW = 52;
    localparam int EW = 11;
    localparam int LN = 2;
    localparam int SW = LN * (MW + 1);

    typedef struct packed {
        logic [SW-1:0] sig;
        logic [LN-1:0] zero;
        logic [LN-1:0] spec;
        logic [1:0]    fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mant_gate_if #(.MANT_W(MW), .EXP_W(EW), .LANES(LN)) bus ();

`ifdef MANT_GATE_STATS_EN
    logic [31:0] gate_cnt;
`endif

    mant_gate_pipe #(.MANT_W(MW), .EXP_W(EW), .LANES(LN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MANT_GATE_STATS_EN
        ,
        .gate_cnt (gate_cnt)
`endif
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     fails  = 0;
    exp_t   sb[$];
    bit     armed = 0;
    bit     last_acc = 0;
    bit     held_v = 0;
    exp_t   held;
    longint model_cnt = 0;

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [LN*MW-1:0] m,
                                   input logic [LN*EW-1:0] e,
                                   input logic md);
        exp_t r;
        logic [MW-1:0] lm;
        logic [EW-1:0] le;
        r = '0;
        for (int l = 0; l < LN; l++) begin
            lm = m[l*MW +: MW];
            le = e[l*EW +: EW];
            if (le == 11'h7FF) begin
                r.sig[l*(MW+1) +: MW+1] = {1'b1, lm};
                r.spec[l] = 1'b1;
            end else if (le != 0) begin
                r.sig[l*(MW+1) +: MW+1] = {1'b1, lm};
            end else if (md) begin
                r.sig[l*(MW+1) +: MW+1] = {1'b0, lm};
                r.zero[l] = (lm == 0);
            end else begin
                r.zero[l] = 1'b1;
                r.fl = r.fl + 2'd1;
            end
        end
        return r;
    endfunction

    // One clock: check at negedge, model the edge, return at edge+1.
    task automatic cyc();
        bit   acc, pop;
        exp_t e;
        @(negedge clk);
        if (held_v) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_sig", bus.out_sig, held.sig);
            chk("hold_zero", bus.out_zero, held.zero);
            chk("hold_spec", bus.out_special, held.spec);
        end
`ifdef MANT_GATE_STATS_EN
        if (armed)
            chk("gate_cnt", gate_cnt, model_cnt[31:0]);
`endif
        acc = !rst && bus.in_valid && bus.in_ready;
        pop = !rst && bus.out_valid && bus.out_ready;
        if (pop) begin
            if (sb.size() == 0) begin
                chk("sb_empty", bus.out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("out_sig", bus.out_sig, e.sig);
                chk("out_zero", bus.out_zero, e.zero);
                chk("out_spec", bus.out_special, e.spec);
                model_cnt = model_cnt + e.fl;
                if (model_cnt > 64'hFFFF_FFFF)
                    model_cnt = 64'hFFFF_FFFF;
            end
        end
        if (acc)
            sb.push_back(model(bus.in_mant, bus.in_exp, bus.in_mode));
        held_v = !rst && bus.out_valid && !bus.out_ready;
        held.sig  = bus.out_sig;
        held.zero = bus.out_zero;
        held.spec = bus.out_special;
        held.fl   = '0;
        @(posedge clk);
        if (rst) begin
            sb.delete();
            model_cnt = 0;
            held_v = 0;
        end
        last_acc = acc;
        #1;
    endtask

    task automatic send(input logic [MW-1:0] m1, input logic [MW-1:0] m0,
                        input logic [EW-1:0] e1, input logic [EW-1:0] e0,
                        input logic md);
        bus.in_valid = 1'b1;
        bus.in_mant  = {m1, m0};
        bus.in_exp   = {e1, e0};
        bus.in_mode  = md;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (last_acc) break;
        end
        chk("send_accept", last_acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0 && !bus.out_valid) break;
            cyc();
        end
        chk("drain", (sb.size() == 0) && !bus.out_valid, 1'b1);
    endtask

    task automatic rnd_beat();
        logic [EW-1:0] e;
        for (int l = 0; l < LN; l++) begin
            bus.in_mant[l*MW +: MW] = MW'({$urandom, $urandom});
            case ($urandom_range(0, 3))
                0:       e = '0;
                1:       e = '1;
                default: e = EW'($urandom);
            endcase
            bus.in_exp[l*EW +: EW] = e;
        end
        bus.in_mode = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b1;
        bus.in_mant   = '0;
        bus.in_exp    = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        armed = 1;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_sig", bus.out_sig, '0);
        chk("rst_zero", bus.out_zero, '0);
        chk("rst_spec", bus.out_special, '0);

        send(52'h1, 52'h8000000000000, 11'h0, 11'h3FF, 1'b0);
        chk("t1_valid", bus.out_valid, 1'b1);
        chk("t1_sig", bus.out_sig, {53'h0, 53'h18000000000000});
        chk("t1_zero", bus.out_zero, 2'b10);
        chk("t1_spec", bus.out_special, 2'b00);

        send(52'h1, 52'h8000000000000, 11'h0, 11'h3FF, 1'b1);
        chk("t2_sig", bus.out_sig, {53'h1, 53'h18000000000000});
        chk("t2_zero", bus.out_zero, 2'b00);

        send(52'h0, 52'h0, 11'h0, 11'h7FF, 1'b1);
        chk("t3_sig", bus.out_sig, {53'h0, 53'h10000000000000});
        chk("t3_zero", bus.out_zero, 2'b10);
        chk("t3_spec", bus.out_special, 2'b01);
        drain();

        bus.out_ready = 1'b0;
        n = 0;
        rnd_beat();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (last_acc) begin
                n++;
                rnd_beat();
            end
        end
        chk("bp_accepted", n, 2);
        chk("bp_ready", bus.in_ready, 1'b0);
        chk("bp_valid", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && n < 4; k++) begin
            cyc();
            if (last_acc) begin
                n++;
                if (n < 4) rnd_beat();
                else bus.in_valid = 1'b0;
            end
        end
        chk("bp_all", n, 4);
        bus.in_valid = 1'b0;
        drain();

        for (int i = 0; i < 100; i++) begin
            rnd_beat();
            bus.in_valid = 1'b1;
            if (i == 60) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                chk("mrst_valid", bus.out_valid, 1'b0);
                chk("mrst_ready", bus.in_ready, 1'b1);
                chk("mrst_sig", bus.out_sig, '0);
`ifdef MANT_GATE_STATS_EN
                chk("mrst_cnt", gate_cnt, 32'h0);
`endif
            end
            cyc();
            chk("tput_acc", last_acc, 1'b1);
            chk("tput_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid = 1'b0;
        drain();

`ifdef MANT_GATE_STATS_EN
        force dut.gate_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.gate_cnt_q;
        model_cnt = 64'hFFFF_FFFE;
        send(52'h5, 52'h3, 11'h0, 11'h0, 1'b0);
        drain();
        chk("sat_cnt", gate_cnt, 32'hFFFF_FFFF);
        send(52'h5, 52'h3, 11'h0, 11'h0, 1'b0);
        drain();
        chk("sat_hold", gate_cnt, 32'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
